// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and FSM encoding shared by alu_exec and ALU control decode (honours ALU_EXEC_BARREL_SHIFT_EN)
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // SHIFT only exists when shifts are done serially.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifndef ALU_EXEC_BARREL_SHIFT_EN
    ST_SHIFT = 2'd1,
`endif
    ST_HOLD  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// rtl/alu_exec_shifter.sv - serial one-bit-per-cycle shifter, or barrel shifter with ALU_EXEC_BARREL_SHIFT_EN
module alu_exec_shifter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
`ifndef ALU_EXEC_BARREL_SHIFT_EN
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  output logic               last,
`endif
  input  logic [3:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] amount,
  output logic [XLEN-1:0]    value
);

`ifdef ALU_EXEC_BARREL_SHIFT_EN

  // Full shift in one cycle straight from the request operands.
  always_comb begin
    value = operand;
    case (op)
      ALU_SLL: value = operand << amount;
      ALU_SRL: value = operand >> amount;
      ALU_SRA: value = $signed(operand) >>> amount;
      default: value = operand;
    endcase
  end

`else

  logic [XLEN-1:0]    work;
  logic [SHAMT_W-1:0] count;
  logic [3:0]         op_q;

  // value is the work register advanced by one bit, so the top can
  // capture it directly on the final step.
  always_comb begin
    value = work;
    case (op_q)
      ALU_SLL: value = {work[XLEN-2:0], 1'b0};
      ALU_SRL: value = {1'b0, work[XLEN-1:1]};
      ALU_SRA: value = {work[XLEN-1], work[XLEN-1:1]};
      default: value = work;
    endcase
  end

  assign last = (count == SHAMT_W'(1));

  // Work register and remaining-bit counter; op is latched so the
  // request inputs are free to change once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      count <= '0;
      op_q  <= ALU_AND;
    end else if (load) begin
      work  <= operand;
      count <= amount;
      op_q  <= op;
    end else if (step) begin
      work  <= value;
      count <= count - SHAMT_W'(1);
    end
  end

`endif

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - handshaked ALU execution unit; ALU_EXEC_BARREL_SHIFT_EN selects single-cycle shifts
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  alu_state_e state, state_next;

  logic               accept;
  logic               capture;
  logic               drop;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    shift_value;
  logic [XLEN-1:0]    single_value;

  assign shamt    = operand_b[SHAMT_W-1:0];
  assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_EXEC_BARREL_SHIFT_EN

  alu_exec_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
    .op      (alu_control),
    .operand (operand_a),
    .amount  (shamt),
    .value   (shift_value)
  );

`else

  logic start_shift;
  logic shift_load;
  logic shift_step;
  logic shift_last;
  logic finish;

  // A zero-amount shift is just a copy, so it takes the one-cycle path.
  assign start_shift = is_shift(alu_control) && (shamt != '0);

  alu_exec_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (shift_load),
    .step    (shift_step),
    .last    (shift_last),
    .op      (alu_control),
    .operand (operand_a),
    .amount  (shamt),
    .value   (shift_value)
  );

`endif

  // One-cycle result for everything except multi-cycle serial shifts.
  always_comb begin
    single_value = '0;
    case (alu_control)
      ALU_AND: single_value = operand_a & operand_b;
      ALU_OR:  single_value = operand_a | operand_b;
      ALU_ADD: single_value = operand_a + operand_b;
      ALU_SUB: single_value = operand_a - operand_b;
      ALU_SLT: single_value = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA: single_value = shift_value;
`else
      ALU_SLL, ALU_SRL, ALU_SRA: single_value = operand_a;
`endif
      default: single_value = '0;
    endcase
  end

  // Next state and datapath strobes; HOLD with out_ready behaves like IDLE
  // so a waiting request is taken in the same cycle the result leaves.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    drop       = 1'b0;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
    shift_load = 1'b0;
    shift_step = 1'b0;
    finish     = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
          if (start_shift) begin
            shift_load = 1'b1;
            drop       = 1'b1;
            state_next = ST_SHIFT;
          end else
`endif
          begin
            capture    = 1'b1;
            state_next = ST_HOLD;
          end
        end else if ((state == ST_HOLD) && out_ready) begin
          drop       = 1'b1;
          state_next = ST_IDLE;
        end
      end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      ST_SHIFT: begin
        shift_step = 1'b1;
        if (shift_last) begin
          finish     = 1'b1;
          state_next = ST_HOLD;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Output register: result and zero only change when a new result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else if (capture) begin
      result    <= single_value;
      zero      <= (single_value == '0);
      out_valid <= 1'b1;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
    end else if (finish) begin
      result    <= shift_value;
      zero      <= (shift_value == '0);
      out_valid <= 1'b1;
`endif
    end else if (drop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec (serial or ALU_EXEC_BARREL_SHIFT_EN build)
module tb_alu_exec;
  import alu_pkg::*;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  localparam bit SERIAL = 1'b0;
`else
  localparam bit SERIAL = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_exec #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
  );

  // Present one request for one edge (unit must be ready), then scramble inputs.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    operand_a   = 32'hDEAD_BEEF;
    operand_b   = 32'h0000_001F;
    alu_control = 4'b1111;
  endtask

  task automatic wait_result(output int cycles, output int busy_bad);
    cycles   = 0;
    busy_bad = 0;
    while (out_valid !== 1'b1 && cycles < 60) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'b0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b expected 1", zero); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h8000_0000) $display("FAIL add_result: got %h expected 80000000", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b0) $display("FAIL add_zero: got %b expected 0", zero); else pass_cnt++;
    drain();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL add_release: got %b expected 0", out_valid); else pass_cnt++;
    send(ALU_SUB, 32'd5, 32'd5);
    total_cnt++; if (result !== 32'h0) $display("FAIL sub_result: got %h expected 00000000", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL sub_zero: got %b expected 1", zero); else pass_cnt++;
    drain();
    send(ALU_ADD, 32'hFFFF_FFFF, 32'h2);
    total_cnt++; if (result !== 32'h1) $display("FAIL add_wrap: got %h expected 00000001", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_slt_logic();
    out_ready = 1'b1;
    send(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
    total_cnt++; if (result !== 32'h1) $display("FAIL slt_neg: got %h expected 00000001", result); else pass_cnt++;
    drain();
    send(ALU_SLT, 32'h1, 32'hFFFF_FFFF);
    total_cnt++; if (result !== 32'h0) $display("FAIL slt_swap: got %h expected 00000000", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL slt_swap_zero: got %b expected 1", zero); else pass_cnt++;
    drain();
    send(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0);
    total_cnt++; if (result !== 32'h0000_00F0) $display("FAIL and_result: got %h expected 000000f0", result); else pass_cnt++;
    drain();
    send(ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0);
    total_cnt++; if (result !== 32'h0000_FFF0) $display("FAIL or_result: got %h expected 0000fff0", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_shift();
    int cycles, busy_bad;
    out_ready = 1'b1;
    send(ALU_SRA, 32'h8000_0000, 32'd4);
    wait_result(cycles, busy_bad);
    total_cnt++; if (cycles !== (SERIAL ? 4 : 0)) $display("FAIL sra_latency: got %0d extra cycles expected %0d", cycles, SERIAL ? 4 : 0); else pass_cnt++;
    total_cnt++; if (busy_bad !== 0) $display("FAIL sra_in_ready_busy: got %0d ready cycles expected 0", busy_bad); else pass_cnt++;
    total_cnt++; if (result !== 32'hF800_0000) $display("FAIL sra_result: got %h expected f8000000", result); else pass_cnt++;
    drain();
    send(ALU_SLL, 32'h1234_5678, 32'h0000_0020);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL shamt0_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h1234_5678) $display("FAIL shamt0_result: got %h expected 12345678", result); else pass_cnt++;
    drain();
    send(ALU_SRL, 32'hF000_0000, 32'h0000_0103);
    wait_result(cycles, busy_bad);
    total_cnt++; if (cycles !== (SERIAL ? 3 : 0)) $display("FAIL srl_latency: got %0d extra cycles expected %0d", cycles, SERIAL ? 3 : 0); else pass_cnt++;
    total_cnt++; if (result !== 32'h1E00_0000) $display("FAIL srl_result: got %h expected 1e000000", result); else pass_cnt++;
    drain();
    send(ALU_SLL, 32'h1, 32'd31);
    wait_result(cycles, busy_bad);
    total_cnt++; if (result !== 32'h8000_0000) $display("FAIL sll31_result: got %h expected 80000000", result); else pass_cnt++;
    drain();
    send(ALU_SRA, 32'h4000_0000, 32'd2);
    wait_result(cycles, busy_bad);
    total_cnt++; if (result !== 32'h1000_0000) $display("FAIL sra_pos_result: got %h expected 10000000", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    int stall_bad;
    out_ready = 1'b0;
    send(ALU_AND, 32'h0000_00FF, 32'h0000_000F);
    total_cnt++; if (result !== 32'h0000_000F) $display("FAIL bp_first: got %h expected 0000000f", result); else pass_cnt++;
    alu_control = ALU_ADD; operand_a = 32'd2; operand_b = 32'd3; in_valid = 1'b1;
    stall_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (result !== 32'h0000_000F || out_valid !== 1'b1 || in_ready !== 1'b0) stall_bad++;
    end
    total_cnt++; if (stall_bad !== 0) $display("FAIL bp_stall: got %0d unstable cycles expected 0", stall_bad); else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_release: got %b expected 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_next_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd5) $display("FAIL bp_next_result: got %h expected 00000005", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    int cycles, busy_bad;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_control = ALU_ADD; operand_a = 32'd1; operand_b = 32'd1;
    @(posedge clk); #1;
    total_cnt++; if (result !== 32'd2) $display("FAIL b2b_first: got %h expected 00000002", result); else pass_cnt++;
    operand_a = 32'd10; operand_b = 32'd20;
    @(posedge clk); #1;
    total_cnt++; if (result !== 32'd30) $display("FAIL b2b_second: got %h expected 0000001e", result); else pass_cnt++;
    alu_control = ALU_SUB; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clk); #1;
    total_cnt++; if (result !== 32'hFFFF_FFFE) $display("FAIL b2b_third: got %h expected fffffffe", result); else pass_cnt++;
    alu_control = ALU_SRL; operand_a = 32'd8; operand_b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== (SERIAL ? 1'b0 : 1'b1)) $display("FAIL b2b_shift_valid: got %b expected %b", out_valid, SERIAL ? 1'b0 : 1'b1); else pass_cnt++;
    wait_result(cycles, busy_bad);
    total_cnt++; if (result !== 32'd2) $display("FAIL b2b_shift_result: got %h expected 00000002", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid_shift();
    int stale;
    out_ready = 1'b1;
    send(ALU_SLL, 32'h1, 32'd20);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL rst_mid_result: got %h expected 00000000", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL rst_mid_zero: got %b expected 1", zero); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
    end
    total_cnt++; if (stale !== 0) $display("FAIL rst_mid_stale: got %0d bad cycles expected 0", stale); else pass_cnt++;
    send(ALU_ADD, 32'd1, 32'd2);
    total_cnt++; if (result !== 32'd3) $display("FAIL rst_mid_after: got %h expected 00000003", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_unsupported();
    out_ready = 1'b1;
    send(4'b1111, 32'd5, 32'd6);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL unsup_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL unsup_result: got %h expected 00000000", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL unsup_zero: got %b expected 1", zero); else pass_cnt++;
    drain();
    send(4'b1000, 32'hFFFF_FFFF, 32'h1);
    total_cnt++; if (result !== 32'h0) $display("FAIL unsup_1000: got %h expected 00000000", result); else pass_cnt++;
    drain();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL unsup_release: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_slt_logic();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_unsupported();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit on the consuming end of the 4-bit alu_control code produced by ALU control decode.
- Takes an operation code plus two XLEN operands over a valid/ready handshake and returns a registered result and zero flag over a second valid/ready handshake.
- Logic ops, ADD, SUB and SLT complete in one cycle.
- Shifts run serially, one bit per cycle, so the datapath stays small in the single-issue core.

Parameters:
- XLEN, 32, operand and result width. Must be a power of two, at least 8.
- SHAMT_W, $clog2(XLEN), width of the shift amount taken from operand_b.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- alu_control  in  4  operation code.
- operand_a  in  XLEN  rs1 value.
- operand_b  in  XLEN  rs2 value or immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0.

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0).
  - 0011 SLL, 0100 SRL, 0101 SRA.
  - Any other code: result 0, zero 1, normal handshake, no hang.
- Arithmetic: ADD and SUB wrap modulo 2^XLEN with no overflow flag. Shift amount is operand_b[SHAMT_W-1:0]; upper bits are ignored.
- States: IDLE, SHIFT, HOLD.
- Reset (async, rst_n low) forces, regardless of state:
  - state IDLE;
  - out_valid 0, result 0, zero 1;
  - shift counter 0;
  - in_ready 1 once rst_n is released.
  - A request or shift in progress is discarded. No result is produced for it.
- in_ready = (state == IDLE) || (state == HOLD && out_ready).
- Accept occurs when in_valid && in_ready.
- Single-cycle op or shift with amount 0: accepted at edge N, then result, zero and out_valid = 1 are visible after edge N, i.e. 1-cycle latency. State becomes HOLD.
- Shift with amount k > 0:
  - On accept, latch operand_a into the work register, load counter = k, enter SHIFT.
  - Each SHIFT cycle shifts one bit (SRA replicates the MSB) and decrements the counter.
  - When the counter reaches 0, move to HOLD with out_valid 1. Latency is k+1 cycles.
  - in_ready is 0 throughout SHIFT.
- HOLD:
  - result and zero stay stable while out_valid && !out_ready.
  - On out_ready, if in_valid is also asserted, the new request is accepted in the same cycle (back-to-back, full throughput for 1-cycle ops). Otherwise return to IDLE with out_valid 0.
- Inputs are sampled only at accept. Operand changes after accept have no effect.
- out_ready while out_valid is 0 is ignored.

Optional Feature:
- Macro: ALU_EXEC_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally by a barrel shifter, have 1-cycle latency like the other ops, and the SHIFT state is not generated.
- Undefined: serial shift as described above.
- Results are identical in both builds. Only latency differs.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit op-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA);
  - the state encoding.
- ALU control decode imports the same constants.
- One sub-module, alu_exec_shifter, holds the work register, the counter and the one-bit step (or the barrel shifter when the macro is defined).
- Handshake and FSM stay in alu_exec.

Test Plan:
- ADD: a=0x7FFFFFFF, b=1, out_ready=1 -> one cycle later out_valid=1, result=0x80000000, zero=0. SUB: a=5, b=5 -> result 0, zero=1.
- SLT signed: a=0xFFFFFFFF, b=1 -> result 1. Swapped operands -> result 0. AND/OR: a=0xF0F0, b=0x0FF0 -> 0x00F0 and 0xFFF0.
- SRA: a=0x80000000, b=4 (serial build) -> in_ready=0 for 4 cycles, out_valid after 5 cycles, result 0xF8000000. Amount 0 -> 1-cycle latency, result=a.
- Backpressure: out_ready=0 for 3 cycles after a result -> result stable and in_ready=0. Then out_ready=1 with a queued in_valid -> new request accepted in that cycle, next result one cycle later.
- Reset: assert rst_n low mid-SLL with b=20 -> out_valid and result clear immediately. After release, in_ready=1 and no stale result appears.
- Unsupported code 1111 -> result 0, zero=1, out_valid after 1 cycle.
